// File: rtl/sweep_pkg.sv
// Shared definitions for the partition sweep controller: FSM encoding,
// default widths and the result-width helpers.
package sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sweep_state_t;

  localparam int DEF_IN_W  = 7;
  localparam int DEF_OUT_W = 4;

  // Sum of popcounts over 2^in_w vectors, each at most out_w.
  function automatic int ham_w(input int in_w, input int out_w);
    return in_w + $clog2(out_w + 1);
  endfunction

  // Sum of absolute differences over 2^in_w vectors, each below 2^out_w.
  function automatic int abs_w(input int in_w, input int out_w);
    return in_w + out_w;
  endfunction

endpackage

// File: rtl/sweep_err_unit.sv
// Per-vector error metrics between an exact and an approximate response:
// inequality flag, Hamming distance and unsigned absolute difference.
module sweep_err_unit
  import sweep_pkg::*;
#(
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic [OUT_W-1:0]             exact,
  input  logic [OUT_W-1:0]             approx,
  output logic                         mismatch,
  output logic [$clog2(OUT_W+1)-1:0]   ham,
  output logic [OUT_W-1:0]             abs_diff
);

  localparam int CW = $clog2(OUT_W + 1);

  logic [OUT_W-1:0] diff_bits;

  assign diff_bits = exact ^ approx;
  assign mismatch  = |diff_bits;
  assign abs_diff  = (exact >= approx) ? (exact - approx) : (approx - exact);

  always_comb begin
    ham = '0;
    for (int i = 0; i < OUT_W; i++) begin
      ham = ham + CW'(diff_bits[i]);
    end
  end

endmodule

// File: rtl/partition_sweep_ctrl.sv
// Exhaustive sweep of a partition's input space, comparing exact and
// approximate responses and accumulating error statistics.
module partition_sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            abort,
  output logic [IN_W-1:0]                 pi_out,
  input  logic [OUT_W-1:0]                exact_po,
  input  logic [OUT_W-1:0]                approx_po,
  output logic                            busy,
  output logic                            done,
  output logic                            res_valid,
  output logic [IN_W:0]                   err_count,
  output logic [ham_w(IN_W, OUT_W)-1:0]   ham_sum,
  output logic [abs_w(IN_W, OUT_W)-1:0]   abs_sum,
  output logic [OUT_W-1:0]                max_abs
);

  localparam int ERR_W = IN_W + 1;
  localparam int HAM_W = ham_w(IN_W, OUT_W);
  localparam int ABS_W = abs_w(IN_W, OUT_W);
  localparam int CW    = $clog2(OUT_W + 1);

  sweep_state_t     state;
  logic [OUT_W-1:0] cap_exact;
  logic [OUT_W-1:0] cap_approx;
  logic             cap_valid;

  logic             vec_mismatch;
  logic [CW-1:0]    vec_ham;
  logic [OUT_W-1:0] vec_abs;
  logic             sweeping;
  logic             launch;
  logic             acc_en;

  sweep_err_unit #(.OUT_W(OUT_W)) u_err (
    .exact    (cap_exact),
    .approx   (cap_approx),
    .mismatch (vec_mismatch),
    .ham      (vec_ham),
    .abs_diff (vec_abs)
  );

  // DONE also accepts a new start so held-start sweeps repeat every 2^IN_W+2 cycles.
  assign sweeping = (state == ST_SWEEP) || (state == ST_DRAIN);
  assign launch   = ((state == ST_IDLE) || (state == ST_DONE)) && start && !abort;
  assign acc_en   = sweeping && cap_valid && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pi_out     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      res_valid  <= 1'b0;
      cap_exact  <= '0;
      cap_approx <= '0;
      cap_valid  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (launch) begin
            state     <= ST_SWEEP;
            pi_out    <= '0;
            busy      <= 1'b1;
            res_valid <= 1'b0;
            cap_valid <= 1'b0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SWEEP: begin
          if (abort) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            cap_valid <= 1'b0;
          end else begin
            cap_exact  <= exact_po;
            cap_approx <= approx_po;
            cap_valid  <= 1'b1;
            if (&pi_out) begin
              state <= ST_DRAIN;
            end else begin
              pi_out <= pi_out + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          cap_valid <= 1'b0;
          busy      <= 1'b0;
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            state     <= ST_DONE;
            done      <= 1'b1;
            res_valid <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Accumulation trails capture by one cycle; widths are sized so nothing wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
      ham_sum   <= '0;
      abs_sum   <= '0;
      max_abs   <= '0;
    end else if (launch) begin
      err_count <= '0;
      ham_sum   <= '0;
      abs_sum   <= '0;
      max_abs   <= '0;
    end else if (acc_en) begin
      err_count <= err_count + ERR_W'(vec_mismatch);
      ham_sum   <= ham_sum + HAM_W'(vec_ham);
      abs_sum   <= abs_sum + ABS_W'(vec_abs);
      if (vec_abs > max_abs) begin
        max_abs <= vec_abs;
      end
    end
  end

endmodule

// File: tb/tb_partition_sweep_ctrl.sv
// Directed-vector bench for partition_sweep_ctrl with hand-computed sweep statistics.
module tb_partition_sweep_ctrl;

  localparam int IN_W  = 7;
  localparam int OUT_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [IN_W-1:0]   pi_out;
  logic [OUT_W-1:0]  exact_po;
  logic [OUT_W-1:0]  approx_po;
  logic              busy;
  logic              done;
  logic              res_valid;
  logic [IN_W:0]     err_count;
  logic [9:0]        ham_sum;
  logic [10:0]       abs_sum;
  logic [OUT_W-1:0]  max_abs;

  int vectors     = 0;
  int miscompares = 0;
  int mode        = 0;

  always #5 clk = ~clk;

  partition_sweep_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .pi_out    (pi_out),
    .exact_po  (exact_po),
    .approx_po (approx_po),
    .busy      (busy),
    .done      (done),
    .res_valid (res_valid),
    .err_count (err_count),
    .ham_sum   (ham_sum),
    .abs_sum   (abs_sum),
    .max_abs   (max_abs)
  );

  // Partition models selected by mode.
  always_comb begin
    exact_po  = pi_out[3:0];
    approx_po = pi_out[3:0];
    case (mode)
      1: approx_po = pi_out[3:0] ^ 4'b0001;
      2: approx_po = 4'b0000;
      3: begin
        exact_po  = 4'b0000;
        approx_po = pi_out[3:0];
      end
      default: ;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int m, output int lat);
    mode  = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 0;
    while (done !== 1'b1 && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic checkResults(input int e_err, input int e_ham, input int e_abs, input int e_max);
    checkOutput("err_count", 32'(err_count), e_err);
    checkOutput("ham_sum",   32'(ham_sum),   e_ham);
    checkOutput("abs_sum",   32'(abs_sum),   e_abs);
    checkOutput("max_abs",   32'(max_abs),   e_max);
    checkOutput("res_valid", 32'(res_valid), 1);
    checkOutput("busy_done", 32'(busy),      0);
  endtask

  initial begin
    int lat;
    int seen;
    int ndone;
    int done_at [3];

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    #3;
    checkOutput("rst_pi",    32'(pi_out),    0);
    checkOutput("rst_busy",  32'(busy),      0);
    checkOutput("rst_done",  32'(done),      0);
    checkOutput("rst_valid", 32'(res_valid), 0);
    checkOutput("rst_err",   32'(err_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // start with abort in IDLE stays idle
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    checkOutput("idle_abort_busy", 32'(busy), 0);

    // exact == approx
    mode  = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("start_busy", 32'(busy),   1);
    checkOutput("start_pi",   32'(pi_out), 0);
    @(posedge clk); #1;
    checkOutput("pi_incr",    32'(pi_out), 1);
    lat = 1;
    while (done !== 1'b1 && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("latency_m0", lat, 129);
    checkResults(0, 0, 0, 0);
    @(posedge clk); #1;
    checkOutput("done_one_cycle", 32'(done), 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idle_hold_valid", 32'(res_valid), 1);
    checkOutput("idle_hold_pi",    32'(pi_out),    127);

    applyStimulus(1, lat);
    checkOutput("latency_m1", lat, 129);
    checkResults(128, 128, 128, 1);

    applyStimulus(2, lat);
    checkOutput("latency_m2", lat, 129);
    checkResults(120, 256, 960, 15);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("idle_hold_err", 32'(err_count), 120);

    applyStimulus(3, lat);
    checkResults(120, 256, 960, 15);

    // abort at sweep cycle 50
    mode  = 2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checkOutput("abort_busy",  32'(busy),      0);
    checkOutput("abort_valid", 32'(res_valid), 0);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    checkOutput("abort_no_done", seen, 0);
    applyStimulus(1, lat);
    checkOutput("latency_post_abort", lat, 129);
    checkResults(128, 128, 128, 1);

    // asynchronous reset mid-sweep
    mode  = 2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (70) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_pi",    32'(pi_out),    0);
    checkOutput("mid_rst_busy",  32'(busy),      0);
    checkOutput("mid_rst_err",   32'(err_count), 0);
    checkOutput("mid_rst_ham",   32'(ham_sum),   0);
    checkOutput("mid_rst_abs",   32'(abs_sum),   0);
    checkOutput("mid_rst_max",   32'(max_abs),   0);
    checkOutput("mid_rst_valid", 32'(res_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(0, lat);
    checkOutput("latency_post_rst", lat, 129);
    checkResults(0, 0, 0, 0);
    @(posedge clk); #1;

    // start held high with an extra pulse mid-sweep: done every 130 cycles
    mode  = 2;
    start = 1'b1;
    @(posedge clk); #1;
    ndone = 0;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      if (n == 60) begin
        start = 1'b0;
        #2;
        start = 1'b1;
      end
      if (done === 1'b1) begin
        if (ndone < 3) done_at[ndone] = n;
        ndone++;
        checkOutput("b2b_err", 32'(err_count), 120);
        if (ndone == 3) start = 1'b0;
      end
    end
    checkOutput("b2b_count", ndone, 3);
    if (ndone >= 3) begin
      checkOutput("b2b_first",   done_at[0], 129);
      checkOutput("b2b_period1", done_at[1] - done_at[0], 130);
      checkOutput("b2b_period2", done_at[2] - done_at[1], 130);
    end
    checkOutput("b2b_idle_busy", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/partition_sweep_ctrl.md
PARTITION_SWEEP_CTRL -- requirements
Module: partition_sweep_ctrl

Interface
REQ-001 Parameter IN_W, default 7, SHALL set the partition input width (the sweep covers 2^IN_W vectors).
REQ-002 Parameter OUT_W, default 4, SHALL set the partition output width.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous and active-low.
REQ-005 start  input  1  request a full exhaustive sweep; sampled only in IDLE.
REQ-006 abort  input  1  cancel a sweep in progress.
REQ-007 pi_out  output  IN_W  registered vector driven to both the exact and the approximate partition.
REQ-008 exact_po  input  OUT_W  combinational response of the exact partition to pi_out.
REQ-009 approx_po  input  OUT_W  combinational response of the approximate partition to pi_out.
REQ-010 busy  output  1  high while a sweep is in progress.
REQ-011 done  output  1  one-cycle pulse when the sweep completes.
REQ-012 res_valid  output  1  high when the result outputs hold a completed sweep.
REQ-013 err_count  output  IN_W+1  number of vectors where exact_po != approx_po.
REQ-014 ham_sum  output  IN_W+$clog2(OUT_W+1)  sum of popcount(exact_po ^ approx_po).
REQ-015 abs_sum  output  IN_W+OUT_W  sum of |exact_po - approx_po|, both operands unsigned.
REQ-016 max_abs  output  OUT_W  maximum |exact_po - approx_po| seen in the sweep.

Function
REQ-017 FSM states SHALL be IDLE, SWEEP, DRAIN, DONE.
REQ-018 IDLE with start=1 and abort=0 SHALL go to SWEEP: pi_out<=0, busy<=1, res_valid<=0, all accumulators cleared to 0.
REQ-019 SWEEP SHALL, every cycle, register the pair (exact_po, approx_po) for the current pi_out into a capture stage and increment pi_out; the edge that captures pi_out = 2^IN_W-1 SHALL move to DRAIN with pi_out held at all-ones.
REQ-020 Accumulation SHALL take place one cycle after capture; DRAIN SHALL accumulate the final captured pair and then go to DONE.
REQ-021 DONE SHALL drive done=1, busy=0 and res_valid=1 for exactly one cycle, then go to IDLE.
REQ-022 Start-to-done latency SHALL be 2^IN_W+1 edges after the edge that samples start (129 at IN_W=7); back-to-back sweeps with start held high SHALL have a period of 2^IN_W+2 cycles.
REQ-023 Result widths are exact for 2^IN_W vectors; accumulators SHALL NOT saturate or wrap.
REQ-024 start while busy SHALL be ignored.
REQ-025 In SWEEP or DRAIN, abort=1 SHALL go to IDLE on the next edge: busy=0, done not pulsed, res_valid stays 0. Partial accumulator values SHALL be held but are undefined for use.
REQ-026 In IDLE, start and abort together SHALL be treated as abort; the FSM stays in IDLE.
REQ-027 In IDLE, pi_out and all results SHALL hold their values.

Reset
REQ-028 When rst_n=0, the block SHALL immediately force, independent of clk: state=IDLE, pi_out=0, busy=0, done=0, res_valid=0, err_count=ham_sum=abs_sum=max_abs=0, capture stage cleared. The same SHALL apply when reset is asserted mid-sweep.

Structure
REQ-029 Package sweep_pkg SHALL hold the FSM state enum, the default IN_W/OUT_W constants and the width helper functions for ham_sum and abs_sum.
REQ-030 The per-vector popcount and absolute-difference logic SHALL be a combinational sub-module, sweep_err_unit.

Verification
REQ-031 approx_po tied to exact_po = pi_out[3:0]: err_count=0, ham_sum=0, abs_sum=0, max_abs=0; done 129 edges after start.
REQ-032 approx_po = exact_po ^ 4'b0001: err_count=128, ham_sum=128, abs_sum=128, max_abs=1.
REQ-033 exact_po = pi_out[3:0], approx_po = 0: err_count=120, ham_sum=256, abs_sum=960, max_abs=15.
REQ-034 abort at sweep cycle 50: busy low on the next cycle, no done pulse, res_valid=0; a subsequent start gives correct results.
REQ-035 rst_n pulsed low at sweep cycle 70: all outputs are 0 with no clock edge required; start after release runs a full sweep.
REQ-036 start held high, with an extra start pulse during busy: no effect mid-sweep; done pulses repeat every 130 cycles.
